// File: rtl/grostl_sbox_bank.sv
// grostl_sbox_bank: pipelined bank of LANES Rijndael S-boxes (forward or inverse
// per word) with valid/ready handshake on both sides and a completed-transfer counter.
// Optional build macro GROSTL_SBOX_PRECHARGE_EN: empty stage registers are forced to
// all-zero data so out_data is 0 whenever out_valid is 0.
module grostl_sbox_bank #(
    parameter int unsigned LANES       = 8,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               in_inv_i,
    input  logic [LANES*8-1:0] in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [LANES*8-1:0] out_data_o,
    output logic [CNT_W-1:0]   xfer_cnt_o
);
    localparam int unsigned W    = LANES * 8;
    localparam int unsigned Last = PIPE_STAGES - 1;

    // ---------------------------------------------------------------------
    // GF(2^8) helpers used only to build the constant tables
    // ---------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; it also maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, sq);  // 254 = bits 1..7
            sq = gf_mul(sq, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // ---------------------------------------------------------------------
    // Constant ROMs, shared by all lanes
    // ---------------------------------------------------------------------
    logic [7:0] fwd_rom [256];
    logic [7:0] inv_rom [256];

    for (genvar v = 0; v < 256; v++) begin : g_rom
        assign fwd_rom[v] = sbox_fwd(8'(v));
        assign inv_rom[v] = sbox_inv(8'(v));
    end

    // Combinational substitution of the incoming word, lane order preserved
    logic [W-1:0] sub_data;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign sub_data[8*i +: 8] = in_inv_i ? inv_rom[in_data_i[8*i +: 8]]
                                             : fwd_rom[in_data_i[8*i +: 8]];
    end

    // ---------------------------------------------------------------------
    // Pipeline stages
    // ---------------------------------------------------------------------
    logic [W-1:0]           data_q       [PIPE_STAGES];
    logic [W-1:0]           data_d       [PIPE_STAGES];
    logic [W-1:0]           stg_in_data  [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] valid_d;
    logic [PIPE_STAGES-1:0] stg_in_valid;
    logic [PIPE_STAGES-1:0] load;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   out_xfer;

    // Stage 0 is fed by the lookup, every later stage by its predecessor
    assign stg_in_valid[0] = in_valid_i;
    assign stg_in_data[0]  = sub_data;

    for (genvar k = 1; k < PIPE_STAGES; k++) begin : g_chain
        assign stg_in_valid[k] = valid_q[k-1];
        assign stg_in_data[k]  = data_q[k-1];
    end

    // Stage k may load if any stage from k to the output has room or the output drains
    always_comb begin
        logic open_slot;
        open_slot = out_ready_i;
        load      = '0;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            open_slot = open_slot | ~valid_q[k];
            load[k]   = open_slot;
        end
    end

    assign in_ready_o = load[0];
    assign out_xfer   = valid_q[Last] & out_ready_i;

    // Next-state for stage valid/data: load from upstream, otherwise hold
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            data_d[k] = data_q[k];
            if (load[k]) begin
                valid_d[k] = stg_in_valid[k];
`ifdef GROSTL_SBOX_PRECHARGE_EN
                data_d[k] = stg_in_valid[k] ? stg_in_data[k] : '0;
`else
                if (stg_in_valid[k]) data_d[k] = stg_in_data[k];
`endif
            end
        end
    end

    // Next-state for the transfer counter, wraps silently
    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer) cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers with synchronous reset; reset discards in-flight words
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) data_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < PIPE_STAGES; k++) data_q[k] <= data_d[k];
        end
    end

    assign out_valid_o = valid_q[Last];
    assign out_data_o  = data_q[Last];
    assign xfer_cnt_o  = cnt_q;

endmodule

// File: tb/tb_grostl_sbox_bank.sv
// tb_grostl_sbox_bank: drives two instances (1-stage with 4-bit counter, 3-stage with
// 16-bit counter) and checks them against a table model built from GF(2^8) arithmetic.
module tb_grostl_sbox_bank;
    localparam int P3 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v1 = 1'b0, inv1 = 1'b0, ordy1 = 1'b1;
    logic [63:0] d1 = '0;
    logic        rdy1, ov1;
    logic [63:0] od1;
    logic [3:0]  cnt1;

    logic        v3 = 1'b0, inv3 = 1'b0, ordy3 = 1'b1;
    logic [63:0] d3 = '0;
    logic        rdy3, ov3;
    logic [63:0] od3;
    logic [15:0] cnt3;

    grostl_sbox_bank #(.LANES(8), .PIPE_STAGES(1), .CNT_W(4)) u_p1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v1), .in_ready_o(rdy1), .in_inv_i(inv1),
        .in_data_i(d1), .out_valid_o(ov1), .out_ready_i(ordy1), .out_data_o(od1),
        .xfer_cnt_o(cnt1)
    );

    grostl_sbox_bank #(.LANES(8), .PIPE_STAGES(P3), .CNT_W(16)) u_p3 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v3), .in_ready_o(rdy3), .in_inv_i(inv3),
        .in_data_i(d3), .out_valid_o(ov3), .out_ready_i(ordy3), .out_data_o(od3),
        .xfer_cnt_o(cnt3)
    );

    logic [7:0]  fwd_t [256];
    logic [7:0]  inv_t [256];
    logic [63:0] q1 [$];
    logic [63:0] q3 [$];
    int n_cmp = 0, n_bad = 0, cyc = 0, n_x1 = 0, n_x3 = 0;
    bit acc3, xf3;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p = 0, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if (x > 255) x = x ^ 'h11b;
        end
        return 8'(p);
    endfunction

    // Model tables: brute-force inverse search, then the affine map bit by bit
    function automatic void build_tables();
        logic [7:0] b, s;
        logic [7:0] c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (a != 0 && gmul(8'(a), 8'(y)) == 8'h01) b = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
            fwd_t[a] = s;
        end
        for (int a = 0; a < 256; a++) inv_t[fwd_t[a]] = 8'(a);
    endfunction

    function automatic logic [63:0] sub_word(input logic [63:0] d, input logic inv);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
        return r;
    endfunction

    // One clock: score handshakes just before the edge, check counters just after it
    task automatic cycle();
        @(negedge clk);
        acc3 = 1'b0;
        xf3  = 1'b0;
        if (rst) begin
            q1.delete();
            q3.delete();
            n_x1 = 0;
            n_x3 = 0;
        end else begin
            if (v1 && rdy1) q1.push_back(sub_word(d1, inv1));
            if (ov1 && ordy1) begin
                if (q1.size() == 0) check("p1_unexpected_out", ov1, 0);
                else check("p1_out_data", od1, q1.pop_front());
                n_x1++;
            end
            if (v3 && rdy3) begin
                q3.push_back(sub_word(d3, inv3));
                acc3 = 1'b1;
            end
            if (ov3 && ordy3) begin
                if (q3.size() == 0) check("p3_unexpected_out", ov3, 0);
                else check("p3_out_data", od3, q3.pop_front());
                n_x3++;
                xf3 = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("p1_xfer_cnt", cnt1, 64'(n_x1 % 16));
        check("p3_xfer_cnt", cnt3, 64'(n_x3 % 65536));
`ifdef GROSTL_SBOX_PRECHARGE_EN
        if (!ov1) check("p1_precharge", od1, 64'h0);
        if (!ov3) check("p3_precharge", od3, 64'h0);
`endif
    endtask

    initial begin
        int n_acc, n_out, gaps, first_acc, first_out, prev_out;
        logic [63:0] snap;
        build_tables();

        // Reset
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        check("rst_p1_out_valid", ov1, 0);
        check("rst_p1_out_data", od1, 0);
        check("rst_p1_in_ready", rdy1, 1);
        check("rst_p3_out_valid", ov3, 0);
        check("rst_p3_out_data", od3, 0);
        check("rst_p3_in_ready", rdy3, 1);

        // Forward reference vector, visible the cycle after accept
        v1 = 1'b1; inv1 = 1'b0; d1 = 64'h00_53_FF_01_10_20_30_40; ordy1 = 1'b1;
        cycle();
        v1 = 1'b0;
        check("vec_fwd_valid", ov1, 1);
        check("vec_fwd_data", od1, 64'h63_ED_16_7C_CA_B7_04_09);
        cycle();
        check("vec_fwd_cnt", cnt1, 1);

        // Inverse reference vector
        v1 = 1'b1; inv1 = 1'b1; d1 = 64'h63_ED_16_7C_CA_B7_04_09;
        cycle();
        v1 = 1'b0;
        check("vec_inv_data", od1, 64'h00_53_FF_01_10_20_30_40);
        cycle();
        check("vec_inv_cnt", cnt1, 2);
        check("idle_valid", ov1, 0);
`ifdef GROSTL_SBOX_PRECHARGE_EN
        check("idle_data_zero", od1, 64'h0);
`else
        check("idle_data_hold", od1, 64'h00_53_FF_01_10_20_30_40);
`endif

        // 3-stage stream of 10 words, out_ready held high
        ordy3 = 1'b1; n_acc = 0; n_out = 0; gaps = 0; first_acc = -1; first_out = -1;
        prev_out = -1;
        v3 = 1'b1; d3 = {$urandom, $urandom}; inv3 = 1'($urandom_range(0, 1));
        for (int t = 0; t < 30; t++) begin
            cycle();
            if (acc3) begin
                if (n_acc == 0) first_acc = cyc - 1;
                n_acc++;
                if (n_acc == 10) v3 = 1'b0;
                else begin
                    d3 = {$urandom, $urandom};
                    inv3 = 1'($urandom_range(0, 1));
                end
            end
            if (xf3) begin
                if (n_out == 0) first_out = cyc - 1;
                else if (cyc - 1 != prev_out + 1) gaps++;
                prev_out = cyc - 1;
                n_out++;
            end
        end
        check("stream_accepts", 64'(n_acc), 10);
        check("stream_outputs", 64'(n_out), 10);
        // accept at edge N, output valid after edge N+2, scored in the cycle ending at N+3
        check("stream_latency", 64'(first_out - first_acc), 64'(P3));
        check("stream_gaps", 64'(gaps), 0);
        check("stream_cnt", cnt3, 10);

        // Stall: out_ready low for 8 cycles while input keeps offering words
        ordy3 = 1'b0; v3 = 1'b1; d3 = {$urandom, $urandom}; n_acc = 0; snap = '0;
        for (int t = 0; t < 8; t++) begin
            cycle();
            if (acc3) begin
                n_acc++;
                d3 = {$urandom, $urandom};
                inv3 = 1'($urandom_range(0, 1));
            end
            if (t == 3) snap = od3;
        end
        check("stall_accepts", 64'(n_acc), 3);
        check("stall_in_ready", rdy3, 0);
        check("stall_out_valid", ov3, 1);
        check("stall_data_stable", od3, snap);
        v3 = 1'b0; ordy3 = 1'b1; n_out = 0;
        for (int t = 0; t < 6; t++) begin
            cycle();
            if (xf3) n_out++;
        end
        check("stall_drained", 64'(n_out), 3);

        // Reset with two words in flight
        ordy3 = 1'b0; v3 = 1'b1;
        for (int t = 0; t < 2; t++) begin
            d3 = {$urandom, $urandom};
            cycle();
        end
        v3 = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_out_valid", ov3, 0);
        check("midrst_cnt", cnt3, 0);
        check("midrst_in_ready", rdy3, 1);
        ordy3 = 1'b1; n_out = 0;
        for (int t = 0; t < 5; t++) begin
            cycle();
            if (xf3) n_out++;
        end
        check("midrst_no_stale", 64'(n_out), 0);

        // 4-bit counter wrap: 17 transfers leave 1
        ordy1 = 1'b1; v1 = 1'b1;
        for (int t = 0; t < 17; t++) begin
            d1 = {$urandom, $urandom};
            inv1 = 1'($urandom_range(0, 1));
            cycle();
        end
        v1 = 1'b0;
        repeat (2) cycle();
        check("wrap_cnt", cnt1, 1);

        // Random traffic on both instances
        for (int t = 0; t < 400; t++) begin
            v1 = ($urandom_range(0, 3) != 0);
            ordy1 = ($urandom_range(0, 2) != 0);
            d1 = {$urandom, $urandom};
            inv1 = 1'($urandom_range(0, 1));
            v3 = ($urandom_range(0, 3) != 0);
            ordy3 = ($urandom_range(0, 2) != 0);
            d3 = {$urandom, $urandom};
            inv3 = 1'($urandom_range(0, 1));
            cycle();
        end
        v1 = 1'b0; v3 = 1'b0; ordy1 = 1'b1; ordy3 = 1'b1;
        repeat (8) cycle();
        check("rand_p1_left", 64'(q1.size()), 0);
        check("rand_p3_left", 64'(q3.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
